// File: rtl/eluks_wb_pkg.sv
// Shared register offsets and FSM state encoding for the ELUKS Wishbone slave.
package eluks_wb_pkg;

  localparam logic [2:0] OFF_PSW0        = 3'd0;
  localparam logic [2:0] OFF_PSW1        = 3'd1;
  localparam logic [2:0] OFF_START_BLOCK = 3'd2;
  localparam logic [2:0] OFF_BLOCK_DIR   = 3'd3;
  localparam logic [2:0] OFF_HMAC_EN     = 3'd4;
  localparam logic [2:0] OFF_RQ_DATA     = 3'd5;
  localparam logic [2:0] OFF_RQ_STATUS   = 3'd6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STAT = 2'd1,
    WAIT_BYTE = 2'd2,
    HOLD      = 2'd3
  } state_t;

endpackage

// File: rtl/eluks_wb_watchdog.sv
// Saturating cycle counter bounding how long the slave waits for a core answer.
module eluks_wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/eluks_wb_slave.sv
// Wishbone B4 classic slave: ELUKS config registers plus status/byte request handshakes.
module eluks_wb_slave
  import eluks_wb_pkg::*;
#(
  parameter int                  WB_DATA   = 32,
  parameter logic [WB_DATA-1:0]  BASE_ADDR = 32'h9200_0000,
  parameter int                  TIMEOUT   = 1024
) (
  input  logic                   wb_clk,
  input  logic                   rst,
  input  logic [WB_DATA-1:0]     wb_adr_i,
  input  logic [WB_DATA-1:0]     wb_dat_i,
  input  logic [WB_DATA/8-1:0]   wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic [WB_DATA-1:0]     wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic [63:0]            psw_o,
  output logic [31:0]            start_block_o,
  output logic [31:0]            block_dir_o,
  output logic                   hmac_en_o,
  output logic                   stat_req_o,
  input  logic                   stat_done_i,
  input  logic                   stat_err_i,
  input  logic [30:0]            stat_blocks_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   byte_pop_o
);

  function automatic logic [WB_DATA-1:0] merge_lanes(input logic [WB_DATA-1:0]   old,
                                                     input logic [WB_DATA-1:0]   wdat,
                                                     input logic [WB_DATA/8-1:0] sel);
    logic [WB_DATA-1:0] res;
    res = old;
    for (int i = 0; i < WB_DATA/8; i++) begin
      if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

  state_t             state, state_nxt;
  logic [WB_DATA-1:0] off, cfg_rd, dat_nxt;
  logic [WB_DATA-1:0] psw_hi, psw_lo, start_block, block_dir;
  logic               hmac_en, req, mapped;
  logic               ack_nxt, err_nxt, stat_req_nxt, pop_nxt, cfg_we, wd_en, wd_expired;

  assign off      = wb_adr_i - BASE_ADDR;
  assign mapped   = (off[WB_DATA-1:3] == '0) && (off[2:0] != 3'd7);
  assign req      = wb_cyc_i & wb_stb_i;
  assign wb_rty_o = 1'b0;

  assign psw_o         = {psw_hi, psw_lo};
  assign start_block_o = start_block;
  assign block_dir_o   = block_dir;
  assign hmac_en_o     = hmac_en;

  eluks_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (wb_clk),
    .rst     (rst),
    .clear   (!wd_en),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Config register read mux; request offsets echo the last response.
  always_comb begin
    cfg_rd = wb_dat_o;
    case (off[2:0])
      OFF_PSW0:        cfg_rd = psw_hi;
      OFF_PSW1:        cfg_rd = psw_lo;
      OFF_START_BLOCK: cfg_rd = start_block;
      OFF_BLOCK_DIR:   cfg_rd = block_dir;
      OFF_HMAC_EN:     cfg_rd = {{(WB_DATA-1){1'b0}}, hmac_en};
      default:         cfg_rd = wb_dat_o;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    ack_nxt      = wb_ack_o;
    err_nxt      = wb_err_o;
    dat_nxt      = wb_dat_o;
    stat_req_nxt = 1'b0;
    pop_nxt      = 1'b0;
    cfg_we       = 1'b0;
    wd_en        = 1'b0;
    case (state)
      IDLE: begin
        ack_nxt = 1'b0;
        err_nxt = 1'b0;
        if (!req) begin
          state_nxt = IDLE;
        end else if (!mapped) begin
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (!wb_we_i) begin
          dat_nxt   = cfg_rd;
          ack_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (off[2:0] == OFF_RQ_STATUS) begin
          stat_req_nxt = 1'b1;
          wd_en        = 1'b1;
          state_nxt    = WAIT_STAT;
        end else if (off[2:0] == OFF_RQ_DATA) begin
          wd_en     = 1'b1;
          state_nxt = WAIT_BYTE;
        end else begin
          cfg_we    = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = HOLD;
        end
      end
      WAIT_STAT: begin
        // A core answer on the expiry cycle still counts as success.
        if (!req) begin
          state_nxt = IDLE;
        end else if (stat_done_i) begin
          dat_nxt   = {stat_err_i, stat_blocks_i};
          ack_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          wd_en = 1'b1;
        end
      end
      WAIT_BYTE: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (byte_valid_i) begin
          pop_nxt   = 1'b1;
          dat_nxt   = {{(WB_DATA-8){1'b0}}, byte_data_i};
          ack_nxt   = 1'b1;
          state_nxt = HOLD;
        end else if (wd_expired) begin
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          wd_en = 1'b1;
        end
      end
      HOLD: begin
        if (!req) begin
          ack_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered bus outputs, core strobes and config registers.
  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) begin
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      stat_req_o  <= 1'b0;
      byte_pop_o  <= 1'b0;
      psw_hi      <= '0;
      psw_lo      <= '0;
      start_block <= '0;
      block_dir   <= '0;
      hmac_en     <= 1'b0;
    end else begin
      wb_ack_o   <= ack_nxt;
      wb_err_o   <= err_nxt;
      wb_dat_o   <= dat_nxt;
      stat_req_o <= stat_req_nxt;
      byte_pop_o <= pop_nxt;
      if (cfg_we) begin
        case (off[2:0])
          OFF_PSW0:        psw_hi      <= merge_lanes(psw_hi, wb_dat_i, wb_sel_i);
          OFF_PSW1:        psw_lo      <= merge_lanes(psw_lo, wb_dat_i, wb_sel_i);
          OFF_START_BLOCK: start_block <= merge_lanes(start_block, wb_dat_i, wb_sel_i);
          OFF_BLOCK_DIR:   block_dir   <= merge_lanes(block_dir, wb_dat_i, wb_sel_i);
          OFF_HMAC_EN:     hmac_en     <= wb_sel_i[0] ? wb_dat_i[0] : hmac_en;
          default:         hmac_en     <= hmac_en;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eluks_wb_slave.sv
// Scoreboard bench for eluks_wb_slave with a small behavioural core model.
module tb_eluks_wb_slave;

  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h9200_0000;

  logic        wb_clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [63:0] psw_o;
  logic [31:0] start_block_o, block_dir_o;
  logic        hmac_en_o, stat_req_o, stat_done_i, stat_err_i;
  logic [30:0] stat_blocks_i;
  logic        byte_valid_i, byte_pop_o;
  logic [7:0]  byte_data_i;

  eluks_wb_slave #(.WB_DATA(32), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .psw_o(psw_o), .start_block_o(start_block_o), .block_dir_o(block_dir_o),
    .hmac_en_o(hmac_en_o), .stat_req_o(stat_req_o), .stat_done_i(stat_done_i),
    .stat_err_i(stat_err_i), .stat_blocks_i(stat_blocks_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .byte_pop_o(byte_pop_o)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    logic        chk_dat;
    int          lat;
  } sb_item_t;

  sb_item_t   sb_q[$];
  logic [7:0] byte_q[$];
  int tests_run = 0, tests_failed = 0;
  int n_req = 0, n_done = 0, n_pop = 0, stat_cnt = 0;
  int stat_delay = 5;
  logic        stat_err_val = 1'b0, byte_en = 1'b0;
  logic [30:0] stat_blk_val = 31'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void expect_rsp(input logic is_err, input logic [31:0] dat,
                                     input logic chk_dat, input int lat);
    sb_item_t e;
    e.is_err = is_err; e.dat = dat; e.chk_dat = chk_dat; e.lat = lat;
    sb_q.push_back(e);
  endfunction

  // Core model: status answer stat_delay cycles after a request, byte FIFO popped by byte_pop_o.
  initial begin
    stat_done_i = 1'b0; stat_err_i = 1'b0; stat_blocks_i = '0;
    byte_valid_i = 1'b0; byte_data_i = 8'h00;
    forever begin
      @(negedge wb_clk);
      stat_done_i = 1'b0;
      if (stat_req_o) begin
        n_req++;
        stat_cnt = stat_delay;
      end else if (stat_cnt > 0) begin
        stat_cnt--;
        if (stat_cnt == 0) begin
          stat_done_i = 1'b1; stat_err_i = stat_err_val; stat_blocks_i = stat_blk_val;
          n_done++;
        end
      end
      if (byte_pop_o) begin
        n_pop++;
        if (byte_q.size() > 0) void'(byte_q.pop_front());
      end
      byte_valid_i = byte_en && (byte_q.size() > 0);
      byte_data_i  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
    end
  end

  task automatic wb_xfer(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
    sb_item_t e;
    int lat;
    logic both;
    @(negedge wb_clk);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0; both = 1'b0;
    do begin
      @(negedge wb_clk);
      lat++;
      if (wb_ack_o && wb_err_o) both = 1'b1;
    end while (!(wb_ack_o || wb_err_o) && lat < 100);
    e = sb_q.pop_front();
    check_eq({tag, "_term"}, {62'd0, wb_err_o, wb_ack_o}, {62'd0, e.is_err, !e.is_err});
    check_eq({tag, "_excl"}, {63'd0, both}, 64'd0);
    if (e.lat > 0) check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
    if (e.chk_dat) check_eq({tag, "_dat"}, {32'd0, wb_dat_o}, {32'd0, e.dat});
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk);
    check_eq({tag, "_fall"}, {62'd0, wb_err_o, wb_ack_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   req0, pop0, done0;
    logic seen;
    logic [7:0] bytes [4];
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge wb_clk);
    check_eq("reset_cfg", psw_o ^ {start_block_o, block_dir_o}, 64'd0);
    check_eq("reset_bus", {29'd0, wb_dat_o, wb_ack_o, wb_err_o, hmac_en_o},
             {29'd0, 32'd0, 3'b000});
    check_eq("reset_strobes", {61'd0, stat_req_o, byte_pop_o, wb_rty_o}, 64'd0);
    rst = 1'b0;

    // PSW writes and read-back
    expect_rsp(1'b0, 32'd0, 1'b0, 1); wb_xfer("psw0_wr", BASE + 32'd0, 1'b1, 32'hDEADBEEF, 4'hF);
    expect_rsp(1'b0, 32'd0, 1'b0, 1); wb_xfer("psw1_wr", BASE + 32'd1, 1'b1, 32'h01234567, 4'hF);
    check_eq("psw_o", psw_o, 64'hDEADBEEF01234567);
    expect_rsp(1'b0, 32'h01234567, 1'b1, 1); wb_xfer("psw1_rd", BASE + 32'd1, 1'b0, 32'd0, 4'hF);

    // Status request, answer after 5 cycles
    req0 = n_req;
    stat_delay = 5; stat_err_val = 1'b0; stat_blk_val = 31'd3;
    expect_rsp(1'b0, 32'h00000003, 1'b1, 7); wb_xfer("stat", BASE + 32'd6, 1'b1, 32'd0, 4'hF);
    repeat (3) @(negedge wb_clk);
    check_eq("stat_hold", {32'd0, wb_dat_o}, 64'h3);
    check_eq("stat_req_cnt", 64'(n_req - req0), 64'd1);
    expect_rsp(1'b0, 32'h00000003, 1'b1, 1); wb_xfer("stat_rd", BASE + 32'd6, 1'b0, 32'd0, 4'hF);
    check_eq("stat_rd_noreq", 64'(n_req - req0), 64'd1);
    stat_delay = 2; stat_err_val = 1'b1; stat_blk_val = 31'h12345;
    expect_rsp(1'b0, 32'h80012345, 1'b1, 4); wb_xfer("stat_err", BASE + 32'd6, 1'b1, 32'd0, 4'hF);

    // Four byte pops
    pop0 = n_pop;
    for (int i = 0; i < 4; i++) byte_q.push_back(bytes[i]);
    byte_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_rsp(1'b0, {24'd0, bytes[i]}, 1'b1, 2);
      wb_xfer("byte", BASE + 32'd5, 1'b1, 32'd0, 4'hF);
    end
    check_eq("pop_cnt", 64'(n_pop - pop0), 64'd4);

    // Byte timeout
    byte_en = 1'b0; pop0 = n_pop;
    expect_rsp(1'b1, 32'd0, 1'b0, TMO + 1); wb_xfer("byte_tmo", BASE + 32'd5, 1'b1, 32'd0, 4'hF);
    check_eq("tmo_nopop", 64'(n_pop - pop0), 64'd0);
    expect_rsp(1'b0, 32'hDEADBEEF, 1'b1, 1); wb_xfer("post_tmo_rd", BASE, 1'b0, 32'd0, 4'hF);

    // Unmapped accesses and byte lanes
    expect_rsp(1'b1, 32'd0, 1'b0, 1); wb_xfer("unmap_wr", BASE + 32'd7, 1'b1, 32'h55, 4'hF);
    expect_rsp(1'b1, 32'd0, 1'b0, 1); wb_xfer("unmap_rd", BASE - 32'd1, 1'b0, 32'd0, 4'hF);
    check_eq("unmap_psw", psw_o, 64'hDEADBEEF01234567);
    expect_rsp(1'b0, 32'd0, 1'b0, 1); wb_xfer("sb_wr", BASE + 32'd2, 1'b1, 32'h123456FF, 4'b0001);
    check_eq("start_block", {32'd0, start_block_o}, 64'hFF);
    expect_rsp(1'b0, 32'd0, 1'b0, 1); wb_xfer("bd_wr", BASE + 32'd3, 1'b1, 32'hAABBCCDD, 4'b1100);
    check_eq("block_dir", {32'd0, block_dir_o}, 64'hAABB0000);
    expect_rsp(1'b0, 32'd0, 1'b0, 1); wb_xfer("hmac_wr", BASE + 32'd4, 1'b1, 32'h1, 4'b0001);
    expect_rsp(1'b0, 32'h1, 1'b1, 1); wb_xfer("hmac_rd", BASE + 32'd4, 1'b0, 32'd0, 4'hF);
    check_eq("hmac_en", {63'd0, hmac_en_o}, 64'd1);

    // Aborted byte request: a later valid byte must stay in the core
    byte_q.push_back(8'h11); pop0 = n_pop;
    @(negedge wb_clk);
    wb_adr_i = BASE + 32'd5; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    byte_en = 1'b1; seen = 1'b0;
    repeat (6) begin @(negedge wb_clk); seen = seen | wb_ack_o | wb_err_o; end
    check_eq("abort_nopop", 64'(n_pop - pop0), 64'd0);
    check_eq("abort_noterm", {63'd0, seen}, 64'd0);
    byte_en = 1'b0; byte_q.delete();

    // Reset while waiting for status
    stat_delay = 4; done0 = n_done;
    @(negedge wb_clk);
    wb_adr_i = BASE + 32'd6; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (2) @(negedge wb_clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_cfg", psw_o | {start_block_o, block_dir_o}, 64'd0);
    check_eq("rst_bus", {29'd0, wb_dat_o, wb_ack_o, wb_err_o, hmac_en_o}, 64'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk);
    rst = 1'b0; seen = 1'b0;
    repeat (8) begin @(negedge wb_clk); seen = seen | wb_ack_o | wb_err_o; end
    check_eq("rst_done_seen", 64'(n_done - done0), 64'd1);
    check_eq("rst_noack", {63'd0, seen}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
